mult_writeback_unit: RTL and testbench



---
 rtl/mult_writeback_unit.sv | 131 +++++++++++++
 tb/tb_mult_writeback_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_writeback_unit.sv
// mult_writeback_unit
// -------------------
// Sequential unsigned shift-add multiplier placed after an 8-entry register
// file. It multiplies the two read-port operands, then writes the
// 2*WIDTH-bit product back as two bytes. The low byte goes to the src1 slot
// and the high byte to the src2 slot. Only one request is in flight at a time
// and the latency is fixed. After acceptance the sequence is:
//   WIDTH cycles CALC, one cycle WB_LO, one cycle WB_HI, then IDLE.
//
// Ports:
//   clock      in   system clock, rising-edge active
//   reset_n    in   synchronous active-low reset
//   go         in   start request, sampled only while idle
//   operand_a  in   multiplicand (register file readData1)
//   operand_b  in   multiplier  (register file readData2)
//   busy       out  high in every non-idle state
//   done       out  one-cycle pulse while the high byte is written
//   wr_en      out  register file write strobe
//   wr_sel     out  register file dest select (0 = src1 slot, 1 = src2 slot)
//   wr_data    out  register file write data, zero outside write-back
//   product    out  last completed product, held until the next completion
module mult_writeback_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               go,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic               busy,
  output logic               done,
  output logic               wr_en,
  output logic               wr_sel,
  output logic [WIDTH-1:0]   wr_data,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WB_LO = 2'd2,
    WB_HI = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   mcand_reg, mcand_next;
  logic [2*WIDTH:0]   acc_reg, acc_next;      // one extra MSB holds the add carry
  logic [CW-1:0]      count_reg, count_next;
  logic [2*WIDTH-1:0] product_reg, product_next;

  // The multiplicand is gated by the current multiplier LSB, one bit at a time.
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     partial_sum;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & acc_reg[0];
    end
  endgenerate

  // acc_reg[2*WIDTH] is always zero during CALC because every iteration ends
  // with a right shift. So a WIDTH+1 bit sum keeps the full carry.
  assign partial_sum = acc_reg[2*WIDTH:WIDTH] + {1'b0, addend};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      mcand_reg   <= '0;
      acc_reg     <= '0;
      count_reg   <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mcand_reg   <= mcand_next;
      acc_reg     <= acc_next;
      count_reg   <= count_next;
      product_reg <= product_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mcand_next   = mcand_reg;
    acc_next     = acc_reg;
    count_next   = count_reg;
    product_next = product_reg;
    case (state_reg)
      IDLE: begin
        if (go) begin
          mcand_next = operand_a;
          acc_next   = {{(WIDTH+1){1'b0}}, operand_b};
          count_next = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        // Add (conditionally) into the upper half, then shift the whole
        // accumulator right by one; the shifted-out bit is the used LSB.
        acc_next   = {1'b0, partial_sum, acc_reg[WIDTH-1:1]};
        count_next = count_reg + 1'b1;
        if (count_reg == CW'(WIDTH - 1)) begin
          state_next = WB_LO;
        end
      end
      WB_LO: begin
        state_next = WB_HI;
      end
      WB_HI: begin
        product_next = acc_reg[2*WIDTH-1:0];
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded only from registered state, so go has no path to them.
  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == WB_HI);
  assign wr_en   = (state_reg == WB_LO) || (state_reg == WB_HI);
  assign wr_sel  = (state_reg == WB_HI);
  assign wr_data = (state_reg == WB_LO) ? acc_reg[WIDTH-1:0] :
                   (state_reg == WB_HI) ? acc_reg[2*WIDTH-1:WIDTH] :
                   '0;
  assign product = product_reg;

endmodule

// File: tb/tb_mult_writeback_unit.sv
// tb_mult_writeback_unit
// ----------------------
// Directed-vector bench for mult_writeback_unit (WIDTH = 8). The reference
// model tracks how many cycles have passed since a request was accepted. It
// derives every output from that count and from a*b. It is compared with the
// DUT on every cycle. Each scenario also checks hand-computed literal results.
module tb_mult_writeback_unit;

  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           go;
  logic [W-1:0]   operand_a;
  logic [W-1:0]   operand_b;
  logic           busy;
  logic           done;
  logic           wr_en;
  logic           wr_sel;
  logic [W-1:0]   wr_data;
  logic [2*W-1:0] product;

  always #5 clock = ~clock;

  mult_writeback_unit #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .go        (go),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .product   (product)
  );

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 is idle. Phase k (1..10) is the k-th cycle after acceptance.
  int             m_phase = 0;
  logic [W-1:0]   m_a = '0;
  logic [W-1:0]   m_b = '0;
  logic [2*W-1:0] m_prod = '0;

  // Observations collected for the literal checks.
  int             done_cnt;
  int             busy_cnt;
  int             wr_cnt;
  logic [W-1:0]   lo_seen;
  logic [W-1:0]   hi_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic clear_obs();
    done_cnt = 0;
    busy_cnt = 0;
    wr_cnt   = 0;
    lo_seen  = 'x;
    hi_seen  = 'x;
  endtask

  // Advance one clock. Update the model from the inputs seen at the rising
  // edge. Then compare all outputs on the falling edge.
  task automatic step();
    logic [2*W-1:0] full;
    @(posedge clock);
    if (!reset_n) begin
      m_phase = 0;
      m_prod  = '0;
    end else if (m_phase == 0) begin
      if (go) begin
        m_a     = operand_a;
        m_b     = operand_b;
        m_phase = 1;
      end
    end else if (m_phase == 10) begin
      m_prod  = 16'(m_a) * 16'(m_b);
      m_phase = 0;
    end else begin
      m_phase++;
    end
    @(negedge clock);
    full = 16'(m_a) * 16'(m_b);
    chk("busy",    32'(busy),    32'(m_phase != 0));
    chk("done",    32'(done),    32'(m_phase == 10));
    chk("wr_en",   32'(wr_en),   32'(m_phase >= 9));
    chk("wr_sel",  32'(wr_sel),  32'(m_phase == 10));
    chk("wr_data", 32'(wr_data),
        (m_phase == 9) ? 32'(full[W-1:0]) : (m_phase == 10) ? 32'(full[2*W-1:W]) : 32'd0);
    chk("product", 32'(product), 32'(m_prod));
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (wr_en) wr_cnt++;
    if (wr_en && !wr_sel) lo_seen = wr_data;
    if (wr_en && wr_sel)  hi_seen = wr_data;
  endtask

  // One full transaction. Operands are scrambled after acceptance to show
  // that only the accepting edge samples them.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                        input logic [2*W-1:0] exp_prod);
    clear_obs();
    operand_a = a;
    operand_b = b;
    go = 1'b1;
    step();
    go = 1'b0;
    operand_a = ~a;
    operand_b = ~b;
    repeat (10) step();
    chk("op_busy_cycles", 32'(busy_cnt), 32'd10);
    chk("op_writes",      32'(wr_cnt),   32'd2);
    chk("op_done_pulses", 32'(done_cnt), 32'd1);
    chk("op_lo_byte",     32'(lo_seen),  32'(exp_lo));
    chk("op_hi_byte",     32'(hi_seen),  32'(exp_hi));
    chk("op_product",     32'(product),  32'(exp_prod));
    chk("op_idle",        32'(busy),     32'd0);
    $display("op a=%0d b=%0d lo=%02h hi=%02h product=%04h", a, b, lo_seen, hi_seen, product);
  endtask

  initial begin
    reset_n   = 1'b0;
    go        = 1'b0;
    operand_a = '0;
    operand_b = '0;
    clear_obs();

    // Reset state
    repeat (2) step();
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_wr_en",   32'(wr_en),   32'd0);
    chk("rst_wr_sel",  32'(wr_sel),  32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    reset_n = 1'b1;
    step();

    // Basic products, carry retention, zero operands
    run_op(8'd13,  8'd11,  8'h8F, 8'h00, 16'h008F);
    run_op(8'd255, 8'd255, 8'h01, 8'hFE, 16'hFE01);
    run_op(8'd0,   8'd200, 8'h00, 8'h00, 16'h0000);
    run_op(8'd200, 8'd0,   8'h00, 8'h00, 16'h0000);

    // go held high continuously; operands change during the first CALC
    clear_obs();
    operand_a = 8'd3;
    operand_b = 8'd5;
    go = 1'b1;
    step();
    step();
    operand_a = 8'd7;
    operand_b = 8'd9;
    repeat (9) step();
    chk("hold_first_product", 32'(product), 32'h000F);
    repeat (11) step();
    go = 1'b0;
    chk("hold_done_pulses", 32'(done_cnt), 32'd2);
    chk("hold_second_product", 32'(product), 32'h003F);
    $display("op hold-go first=000F second=%04h dones=%0d", product, done_cnt);
    step();

    // Reset during the 4th CALC cycle drops the in-flight result
    operand_a = 8'd100;
    operand_b = 8'd100;
    go = 1'b1;
    step();
    go = 1'b0;
    repeat (3) step();
    clear_obs();
    reset_n = 1'b0;
    step();
    chk("midrst_busy",    32'(busy),    32'd0);
    chk("midrst_wr_en",   32'(wr_en),   32'd0);
    chk("midrst_product", 32'(product), 32'd0);
    reset_n = 1'b1;
    repeat (12) step();
    chk("midrst_no_writes", 32'(wr_cnt), 32'd0);
    $display("op reset-mid-calc writes=%0d product=%04h", wr_cnt, product);
    run_op(8'd2, 8'd3, 8'h06, 8'h00, 16'h0006);

    // go pulsed during WB_LO is ignored
    clear_obs();
    operand_a = 8'd4;
    operand_b = 8'd6;
    go = 1'b1;
    step();
    go = 1'b0;
    repeat (8) step();
    chk("wbgo_in_wb_lo", 32'(wr_en & ~wr_sel), 32'd1);
    operand_a = 8'd9;
    operand_b = 8'd9;
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    chk("wbgo_idle_after_done", 32'(busy), 32'd0);
    repeat (12) step();
    chk("wbgo_done_pulses", 32'(done_cnt), 32'd1);
    chk("wbgo_product",     32'(product),  32'h0018);
    $display("op go-in-wb_lo dones=%0d product=%04h", done_cnt, product);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
